branch_redirect_ctrl: RTL and testbench

Consumes branch-resolution results from the branch unit and turns mispredictions into a backend flush and a front-end fetch redirect. Tracks the oldest unresolved mispredict by ROB age, squashes younger ones, and holds the redirect until fetch accepts it. Sits between the branch unit output stage, the ROB/rename flush logic and the fetch PC mux.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_stats_ctr.sv | 32 +++
 rtl/branch_redirect_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and helpers for branch redirect control
//
// Purpose : ROB tag type, recovery FSM state encoding, default widths and
//           the ROB age helper used when ordering mispredicts.
// Contents: ROB_TAG_W_DEFAULT, XLEN_DEFAULT, rob_tag_t, redir_state_e,
//           rob_age().
package branch_pkg;

   localparam int ROB_TAG_W_DEFAULT = 6;
   localparam int XLEN_DEFAULT      = 32;

   typedef logic [ROB_TAG_W_DEFAULT-1:0] rob_tag_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      REDIRECT = 2'd2
   } redir_state_e;

   // Distance of a tag from the ROB head; smaller means older. The
   // subtraction wraps naturally at the ROB depth.
   function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
      return tag - head;
   endfunction

endpackage

// File: rtl/branch_stats_ctr.sv
// rtl/branch_stats_ctr.sv - resolved-branch and mispredict wrap counters
//
// Purpose : two free-running counters that wrap at 2^STAT_W.
// Ports   : clk, rst (sync, active-high)
//           branch_inc      - count one resolved branch
//           mispredict_inc  - count one mispredict
//           branches        - resolved-branch count
//           mispredicts     - mispredict count
module branch_stats_ctr #(
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              branch_inc,
   input  logic              mispredict_inc,
   output logic [STAT_W-1:0] branches,
   output logic [STAT_W-1:0] mispredicts
);

   always_ff @(posedge clk) begin
      if (rst) begin
         branches    <= '0;
         mispredicts <= '0;
      end else begin
         if (branch_inc)
            branches <= branches + 1'b1;
         if (mispredict_inc)
            mispredicts <= mispredicts + 1'b1;
      end
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - mispredict recovery: backend flush and fetch redirect
//
// Purpose : turns branch-unit mispredictions into a one-cycle flush pulse
//           followed by a held fetch redirect. Keeps only the oldest
//           outstanding mispredict (by ROB age); younger ones are dropped
//           because the flush already squashes them.
// Ports   : clk, rst (sync, active-high)
//           res_valid_i/res_rob_tag_i/res_mispredict_i/res_taken_i/res_target_i
//                              - branch resolution input
//           rob_head_i         - oldest ROB tag, reference for age
//           flush_o/flush_tag_o - squash everything younger than flush_tag_o
//           redirect_valid_o/redirect_pc_o/redirect_ready_i - fetch redirect
//           busy_o             - recovery in progress
//           stat_branches_o/stat_mispredicts_o - statistics
// Config  : BRANCH_STATS_EN enables the statistics counters; otherwise the
//           stat ports are tied to zero.
module branch_redirect_ctrl
   import branch_pkg::*;
#(
   parameter int ROB_TAG_W = ROB_TAG_W_DEFAULT,
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int STAT_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 res_valid_i,
   input  logic [ROB_TAG_W-1:0] res_rob_tag_i,
   input  logic                 res_mispredict_i,
   input  logic                 res_taken_i,
   input  logic [XLEN-1:0]      res_target_i,
   input  logic [ROB_TAG_W-1:0] rob_head_i,
   output logic                 flush_o,
   output logic [ROB_TAG_W-1:0] flush_tag_o,
   output logic                 redirect_valid_o,
   output logic [XLEN-1:0]      redirect_pc_o,
   input  logic                 redirect_ready_i,
   output logic                 busy_o,
   output logic [STAT_W-1:0]    stat_branches_o,
   output logic [STAT_W-1:0]    stat_mispredicts_o
);

   redir_state_e         state;
   logic [ROB_TAG_W-1:0] hold_tag;
   logic [XLEN-1:0]      hold_pc;

   logic                 mispredict;
   logic [ROB_TAG_W-1:0] new_age;
   logic [ROB_TAG_W-1:0] hold_age;
   logic                 older;
   logic                 capture;

   // Direction is not needed for recovery; only the target matters.
   logic unused_taken;
   assign unused_taken = res_taken_i;

   assign mispredict = res_valid_i & res_mispredict_i;

   // Ages are computed at the ROB parameter width so wrap matches ROB depth.
   assign new_age  = res_rob_tag_i - rob_head_i;
   assign hold_age = hold_tag - rob_head_i;
   assign older    = mispredict && (new_age < hold_age);

   // In IDLE any mispredict starts recovery; while busy only a strictly
   // older one replaces the held branch.
   assign capture = (state == IDLE) ? mispredict : older;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (mispredict)
                  state <= FLUSH;
            end
            FLUSH: begin
               // An older mispredict here re-arms the flush for next cycle.
               if (!older)
                  state <= REDIRECT;
            end
            REDIRECT: begin
               // Older mispredict wins over a same-cycle handshake: the old
               // redirect is either withdrawn or already consumed, and the
               // new branch needs its own flush first.
               if (older)
                  state <= FLUSH;
               else if (redirect_ready_i)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_tag <= '0;
         hold_pc  <= '0;
      end else if (capture) begin
         hold_tag <= res_rob_tag_i;
         hold_pc  <= res_target_i;
      end
   end

   // Outputs decode registered state only; no input reaches them directly.
   assign flush_o          = (state == FLUSH);
   assign redirect_valid_o = (state == REDIRECT);
   assign busy_o           = (state != IDLE);
   assign flush_tag_o      = hold_tag;
   assign redirect_pc_o    = hold_pc;

`ifdef BRANCH_STATS_EN
   branch_stats_ctr #(
      .STAT_W(STAT_W)
   ) u_stats (
      .clk            (clk),
      .rst            (rst),
      .branch_inc     (res_valid_i),
      .mispredict_inc (mispredict),
      .branches       (stat_branches_o),
      .mispredicts    (stat_mispredicts_o)
   );
`else
   assign stat_branches_o    = '0;
   assign stat_mispredicts_o = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

   localparam int TW = 6;
   localparam int XW = 32;
   localparam int SW = 32;
`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          res_valid;
   logic [TW-1:0] res_rob_tag;
   logic          res_mispredict;
   logic          res_taken;
   logic [XW-1:0] res_target;
   logic [TW-1:0] rob_head;
   logic          flush;
   logic [TW-1:0] flush_tag;
   logic          redirect_valid;
   logic [XW-1:0] redirect_pc;
   logic          redirect_ready;
   logic          busy;
   logic [SW-1:0] stat_branches;
   logic [SW-1:0] stat_mispredicts;

   int checks = 0;
   int errors = 0;

   // Reference model: the single oldest outstanding mispredict and whether
   // its flush has been announced yet.
   bit          m_busy;
   bit          m_flushing;
   int          m_tag;
   logic [31:0] m_pc;
   logic [31:0] m_br;
   logic [31:0] m_mp;

   branch_redirect_ctrl #(
      .ROB_TAG_W(TW),
      .XLEN(XW),
      .STAT_W(SW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .res_valid_i        (res_valid),
      .res_rob_tag_i      (res_rob_tag),
      .res_mispredict_i   (res_mispredict),
      .res_taken_i        (res_taken),
      .res_target_i       (res_target),
      .rob_head_i         (rob_head),
      .flush_o            (flush),
      .flush_tag_o        (flush_tag),
      .redirect_valid_o   (redirect_valid),
      .redirect_pc_o      (redirect_pc),
      .redirect_ready_i   (redirect_ready),
      .busy_o             (busy),
      .stat_branches_o    (stat_branches),
      .stat_mispredicts_o (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [40:0] obs = {flush, flush_tag, redirect_valid, redirect_pc, busy};

   function automatic logic [40:0] ex(input bit f, input int t, input bit rv,
                                      input logic [31:0] pc, input bit b);
      logic [5:0] t6;
      t6 = t[5:0];
      return {f, t6, rv, pc, b};
   endfunction

   function automatic int age(input int t, input int h);
      return (((t - h) % 64) + 64) % 64;
   endfunction

   task automatic drive(input bit v, input bit mp, input int tag, input logic [31:0] tgt);
      res_valid      = v;
      res_mispredict = mp;
      res_rob_tag    = tag[TW-1:0];
      res_target     = tgt;
      res_taken      = 1'($urandom_range(0, 1));
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 0, 32'h0);
   endtask

   // Advance one clock, update the model with the inputs seen at the edge.
   task automatic tick();
      bit mp;
      @(posedge clk);
      mp = res_valid && res_mispredict;
      if (rst) begin
         m_busy = 0; m_flushing = 0; m_tag = 0; m_pc = '0; m_br = '0; m_mp = '0;
      end else begin
         if (res_valid) m_br = m_br + 1;
         if (mp) m_mp = m_mp + 1;
         if (!m_busy) begin
            if (mp) begin
               m_busy = 1; m_flushing = 1; m_tag = int'(res_rob_tag); m_pc = res_target;
            end
         end else if (mp && age(int'(res_rob_tag), int'(rob_head)) < age(m_tag, int'(rob_head))) begin
            m_flushing = 1; m_tag = int'(res_rob_tag); m_pc = res_target;
         end else if (m_flushing) begin
            m_flushing = 0;
         end else if (redirect_ready) begin
            m_busy = 0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_in();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rob_head = '0; redirect_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (obs !== 41'd0 || stat_branches !== '0 || stat_mispredicts !== '0) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got %h/%h/%h expected 0", i, obs, stat_branches, stat_mispredicts);
         end
      end
   endtask

   task automatic test_basic();
      rob_head = 6'd0; redirect_ready = 1'b1;
      drive(1, 1, 5, 32'h1000); tick(); idle_in();
      checks++;
      if (obs !== ex(1, 5, 0, 32'h1000, 1)) begin errors++;
         $display("FAIL basic_flush: got %h expected %h", obs, ex(1, 5, 0, 32'h1000, 1)); end
      tick();
      checks++;
      if (obs !== ex(0, 5, 1, 32'h1000, 1)) begin errors++;
         $display("FAIL basic_redirect: got %h expected %h", obs, ex(0, 5, 1, 32'h1000, 1)); end
      tick();
      checks++;
      if (obs !== ex(0, 5, 0, 32'h1000, 0)) begin errors++;
         $display("FAIL basic_done: got %h expected %h", obs, ex(0, 5, 0, 32'h1000, 0)); end
   endtask

   task automatic test_older_replace();
      rob_head = 6'd0; redirect_ready = 1'b1;
      drive(1, 1, 9, 32'h900); tick();
      checks++;
      if (obs !== ex(1, 9, 0, 32'h900, 1)) begin errors++;
         $display("FAIL older_first: got %h expected %h", obs, ex(1, 9, 0, 32'h900, 1)); end
      drive(1, 1, 3, 32'h2000); tick(); idle_in();
      checks++;
      if (obs !== ex(1, 3, 0, 32'h2000, 1)) begin errors++;
         $display("FAIL older_second_flush: got %h expected %h", obs, ex(1, 3, 0, 32'h2000, 1)); end
      tick();
      checks++;
      if (obs !== ex(0, 3, 1, 32'h2000, 1)) begin errors++;
         $display("FAIL older_redirect: got %h expected %h", obs, ex(0, 3, 1, 32'h2000, 1)); end
      tick();
      checks++;
      if (obs !== ex(0, 3, 0, 32'h2000, 0)) begin errors++;
         $display("FAIL older_done: got %h expected %h", obs, ex(0, 3, 0, 32'h2000, 0)); end
   endtask

   task automatic test_wrap();
      rob_head = 6'd60; redirect_ready = 1'b1;
      drive(1, 1, 2, 32'h22); tick();
      drive(1, 1, 62, 32'h62); tick(); idle_in();
      checks++;
      if (obs !== ex(1, 62, 0, 32'h62, 1)) begin errors++;
         $display("FAIL wrap_replace: got %h expected %h", obs, ex(1, 62, 0, 32'h62, 1)); end
      tick(); tick();
      checks++;
      if (obs !== ex(0, 62, 0, 32'h62, 0)) begin errors++;
         $display("FAIL wrap_done: got %h expected %h", obs, ex(0, 62, 0, 32'h62, 0)); end
      drive(1, 1, 62, 32'h620); tick();
      drive(1, 1, 2, 32'h20); tick(); idle_in();
      checks++;
      if (obs !== ex(0, 62, 1, 32'h620, 1)) begin errors++;
         $display("FAIL wrap_ignore_younger: got %h expected %h", obs, ex(0, 62, 1, 32'h620, 1)); end
      tick();
      checks++;
      if (obs !== ex(0, 62, 0, 32'h620, 0)) begin errors++;
         $display("FAIL wrap_ignore_done: got %h expected %h", obs, ex(0, 62, 0, 32'h620, 0)); end
   endtask

   task automatic test_ready_stall();
      rob_head = 6'd0; redirect_ready = 1'b0;
      drive(1, 1, 20, 32'h3000); tick(); idle_in(); tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (obs !== ex(0, 20, 1, 32'h3000, 1)) begin errors++;
            $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, ex(0, 20, 1, 32'h3000, 1)); end
      end
      drive(1, 1, 10, 32'h4000); tick(); idle_in();
      checks++;
      if (obs !== ex(1, 10, 0, 32'h4000, 1)) begin errors++;
         $display("FAIL stall_withdraw: got %h expected %h", obs, ex(1, 10, 0, 32'h4000, 1)); end
      tick();
      checks++;
      if (obs !== ex(0, 10, 1, 32'h4000, 1)) begin errors++;
         $display("FAIL stall_new_pc: got %h expected %h", obs, ex(0, 10, 1, 32'h4000, 1)); end
      // Handshake and older mispredict in the same cycle.
      redirect_ready = 1'b1;
      drive(1, 1, 4, 32'h5000); tick(); idle_in();
      checks++;
      if (obs !== ex(1, 4, 0, 32'h5000, 1)) begin errors++;
         $display("FAIL hs_older_flush: got %h expected %h", obs, ex(1, 4, 0, 32'h5000, 1)); end
      tick();
   endtask

   task automatic test_back_to_back();
      // Current cycle is a REDIRECT handshake (ready=1).
      rob_head = 6'd0; redirect_ready = 1'b1;
      tick();
      checks++;
      if (obs !== ex(0, 4, 0, 32'h5000, 0)) begin errors++;
         $display("FAIL b2b_idle: got %h expected %h", obs, ex(0, 4, 0, 32'h5000, 0)); end
      drive(1, 1, 40, 32'h6000); tick(); idle_in();
      checks++;
      if (obs !== ex(1, 40, 0, 32'h6000, 1)) begin errors++;
         $display("FAIL b2b_accept: got %h expected %h", obs, ex(1, 40, 0, 32'h6000, 1)); end
      tick(); tick();
      checks++;
      if (obs !== ex(0, 40, 0, 32'h6000, 0)) begin errors++;
         $display("FAIL b2b_done: got %h expected %h", obs, ex(0, 40, 0, 32'h6000, 0)); end
   endtask

   task automatic test_stats_reset();
      logic [31:0] eb, em;
      rob_head = 6'd0; redirect_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1, (i == 0 || i == 3 || i == 6), 10 + i, 32'h100 * i);
         tick();
      end
      idle_in(); tick(); tick(); tick();
      eb = STATS ? 32'd7 : 32'd0;
      em = STATS ? 32'd3 : 32'd0;
      checks++;
      if (stat_branches !== eb || stat_mispredicts !== em) begin errors++;
         $display("FAIL stats_count: got %0d/%0d expected %0d/%0d", stat_branches, stat_mispredicts, eb, em); end
      redirect_ready = 1'b0;
      drive(1, 1, 7, 32'h7000); tick(); idle_in(); tick();
      checks++;
      if (obs !== ex(0, 7, 1, 32'h7000, 1)) begin errors++;
         $display("FAIL stats_pre_rst: got %h expected %h", obs, ex(0, 7, 1, 32'h7000, 1)); end
      do_reset();
      checks++;
      if (obs !== 41'd0 || stat_branches !== '0 || stat_mispredicts !== '0) begin errors++;
         $display("FAIL rst_mid_redirect: got %h/%0d/%0d expected 0", obs, stat_branches, stat_mispredicts); end
   endtask

   task automatic test_random();
      logic [40:0] exp_obs;
      do_reset();
      rob_head = 6'($urandom_range(0, 63));
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) rob_head = 6'($urandom_range(0, 63));
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 63)), $urandom);
         redirect_ready = ($urandom_range(0, 2) != 0);
         tick();
         exp_obs = ex(m_busy && m_flushing, m_tag, m_busy && !m_flushing, m_pc, m_busy);
         checks++;
         if (obs !== exp_obs) begin errors++;
            $display("FAIL random_outputs[%0d]: got %h expected %h", i, obs, exp_obs); end
         checks++;
         if (stat_branches !== (STATS ? m_br : 32'd0) || stat_mispredicts !== (STATS ? m_mp : 32'd0)) begin
            errors++;
            $display("FAIL random_stats[%0d]: got %0d/%0d expected %0d/%0d", i, stat_branches,
                     stat_mispredicts, STATS ? m_br : 32'd0, STATS ? m_mp : 32'd0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; rob_head = '0; redirect_ready = 1'b0;
      res_valid = 1'b0; res_mispredict = 1'b0; res_taken = 1'b0;
      res_rob_tag = '0; res_target = '0;
      m_busy = 0; m_flushing = 0; m_tag = 0; m_pc = '0; m_br = '0; m_mp = '0;
      test_reset();
      test_basic();
      test_older_replace();
      test_wrap();
      test_ready_stall();
      test_back_to_back();
      test_stats_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
